piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 shifts out the MSB first, 0 shifts out the LSB first.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 0, giving the number of mandatory idle cycles after each frame; legal range 0..15.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port load_valid, input, 1 bit: the producer offers load_data.
REQ-007 The block SHALL have port load_data, input, WIDTH bits: the parallel word to serialize.
REQ-008 The block SHALL have port load_ready, output, 1 bit: the serializer accepts a word this cycle.
REQ-009 The block SHALL have port ser_out, output, 1 bit: serial data, driving the d_in of the downstream shift-register chain.
REQ-010 The block SHALL have port ser_frame, output, 1 bit: high while ser_out carries a valid data bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse coincident with the last bit of a frame.

Function
REQ-013 A transfer SHALL occur at a rising edge where load_valid and load_ready are both high; load_data SHALL be captured only at that edge.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-015 In IDLE: load_ready=1, ser_frame=0, ser_out=0; on a transfer the FSM SHALL go to SHIFT with bit counter=0.
REQ-016 The first data bit SHALL appear on ser_out in the cycle after the transfer edge; bit i SHALL appear at transfer+1+i, for i=0..WIDTH-1.
REQ-017 In SHIFT: ser_frame=1, and the bit counter SHALL increment by 1 each cycle, with width $clog2(WIDTH).
REQ-018 In SHIFT, load_ready SHALL be high only when counter==WIDTH-1 and GAP_CYCLES==0; at all other counts, load_valid SHALL be ignored.
REQ-019 At counter==WIDTH-1, if a transfer occurs, the new word SHALL start the next cycle with no bubble and the FSM SHALL stay in SHIFT.
REQ-020 At counter==WIDTH-1 with no transfer: if GAP_CYCLES>0 the FSM SHALL go to GAP, otherwise to IDLE.
REQ-021 In GAP: ser_out=0, ser_frame=0, load_ready=0; after exactly GAP_CYCLES cycles the FSM SHALL go to IDLE.
REQ-022 done SHALL be high exactly in the cycle that presents bit WIDTH-1, and low otherwise.
REQ-023 ser_out, ser_frame and done SHALL be register outputs; load_ready SHALL be decoded from state and counter only, with no combinational path from load_valid.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 While rst=0: state=IDLE, counters=0, shift register=0, ser_out=0, ser_frame=0, done=0, busy=0; load_ready SHALL be 0 while reset is asserted.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no further bits emitted; the first edge after release SHALL find the block in IDLE with load_ready=1.

Structure
REQ-027 Package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT, GAP) and a function computing the counter width.
REQ-028 The bit counter with terminal-count flag SHALL be a sub-module named piso_bit_cnt; the bit counter and the GAP counter SHALL each instantiate it.
REQ-029 No other sub-modules SHALL be used.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1: load 0xA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles +1..+8; ser_frame high for exactly 8 cycles; done on cycle +8.
REQ-031 MSB_FIRST=0: load 0xA5 -> ser_out 1,0,1,0,0,1,0,1 (LSB first); load 0x01 -> 1,0,0,0,0,0,0,0.
REQ-032 GAP_CYCLES=0: 0xFF then 0x00 back-to-back -> ser_frame high for 16 contiguous cycles, ser_out eight 1s then eight 0s, done pulses at cycles +8 and +16.
REQ-033 GAP_CYCLES=2: load_valid held high -> ser_frame low and load_ready low for exactly 2 cycles between frames, plus 1 IDLE cycle before the next transfer.
REQ-034 load_valid high with new data in SHIFT at counter 3 -> no transfer, the frame is unchanged, and the word is accepted only at a legal load_ready.
REQ-035 rst pulsed low after 3 bits of 0xA5 -> ser_out=0, ser_frame=0, busy=0 immediately; load_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Clearable up-counter with a registered terminal-count flag (o_tc == (count == MaxVal)).
module piso_bit_cnt #(
  parameter int unsigned Width  = 1,
  parameter int unsigned MaxVal = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [Width-1:0] r_cnt;
  logic [Width-1:0] w_cnt_next;
  logic             r_tc;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en) begin
      w_cnt_next = r_cnt + Width'(1);
    end
  end

  // The flag is registered alongside the count so it can feed outputs that must be flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_tc  <= (MaxVal == 0);
    end else begin
      r_cnt <= w_cnt_next;
      r_tc  <= (w_cnt_next == Width'(MaxVal));
    end
  end

  assign o_tc = r_tc;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load handshake and optional idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW   = cnt_width(WIDTH);
  localparam int unsigned GapW   = cnt_width(GAP_CYCLES);
  localparam int unsigned GapMax = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit          HasGap = (GAP_CYCLES > 0);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic             r_ser_out, w_ser_out_next;
  logic             r_ser_frame;
  logic             w_xfer;
  logic             w_bit_tc;
  logic             w_gap_tc;

  // Gated by rst so no word is offered as accepted while the block is held in reset.
  assign load_ready = rst & ((r_state == IDLE) | ((r_state == SHIFT) & w_bit_tc & ~HasGap));
  assign w_xfer     = load_valid & load_ready;

  piso_bit_cnt #(
    .Width (CntW),
    .MaxVal(WIDTH - 1)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_xfer | ((r_state == SHIFT) & w_bit_tc)),
    .i_en (r_state == SHIFT),
    .o_tc (w_bit_tc)
  );

  piso_bit_cnt #(
    .Width (GapW),
    .MaxVal(GapMax)
  ) u_gap_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr((r_state != GAP) | w_gap_tc),
    .i_en (r_state == GAP),
    .o_tc (w_gap_tc)
  );

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = '0;
    w_ser_out_next = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_bit_tc) begin
          if (w_xfer)      w_state_next = SHIFT;
          else if (HasGap) w_state_next = GAP;
          else             w_state_next = IDLE;
        end
      end
      GAP: begin
        if (w_gap_tc) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // The first bit goes straight to ser_out; the shift register holds the remainder.
    if (w_xfer) begin
      if (MSB_FIRST) begin
        w_ser_out_next = load_data[WIDTH-1];
        w_shreg_next   = {load_data[WIDTH-2:0], 1'b0};
      end else begin
        w_ser_out_next = load_data[0];
        w_shreg_next   = {1'b0, load_data[WIDTH-1:1]};
      end
    end else if ((r_state == SHIFT) && !w_bit_tc) begin
      if (MSB_FIRST) begin
        w_ser_out_next = r_shreg[WIDTH-1];
        w_shreg_next   = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        w_ser_out_next = r_shreg[0];
        w_shreg_next   = {1'b0, r_shreg[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_frame <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shreg     <= w_shreg_next;
      r_ser_out   <= w_ser_out_next;
      r_ser_frame <= (w_state_next == SHIFT);
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_frame = r_ser_frame;
  assign busy      = (r_state != IDLE);
  // Bit-counter flag is a flop that is high only while bit WIDTH-1 is on ser_out.
  assign done      = w_bit_tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations checked against a bit-level scoreboard.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      lv, lr, so, sf, bz, dn;
  logic [2:0][7:0] ld;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_fail   = 0;

  // dut0: MSB first, no gap; dut1: LSB first, no gap; dut2: MSB first, two-cycle gap.
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
    .ser_out(so[0]), .ser_frame(sf[0]), .busy(bz[0]), .done(dn[0])
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
    .ser_out(so[1]), .ser_frame(sf[1]), .busy(bz[1]), .done(dn[1])
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
    .ser_out(so[2]), .ser_frame(sf[2]), .busy(bz[2]), .done(dn[2])
  );

  // Expected bit sequence for an accepted word; dut1 is the only LSB-first instance.
  task automatic push_word(input int k, input logic [7:0] d);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b    = (k == 1) ? d[i] : d[7-i];
      e.last = (i == 7);
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every framed bit pops one expectation; unframed cycles must be quiet.
  always @(posedge clk) begin : monitor
    exp_t e;
    bit   have;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (sf[k] === 1'b1) begin
        have = 1'b0;
        case (k)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_checks++;
        if (!have) begin
          n_fail++;
          $display("FAIL sb_unexpected dut%0d t=%0t: ser_frame=1 but no bit expected", k, $time);
        end else begin
          if (so[k] !== e.b) begin
            n_fail++;
            $display("FAIL sb_ser_out dut%0d t=%0t: got %b expected %b", k, $time, so[k], e.b);
          end
          n_checks++;
          if (dn[k] !== e.last) begin
            n_fail++;
            $display("FAIL sb_done dut%0d t=%0t: got %b expected %b", k, $time, dn[k], e.last);
          end
        end
      end else begin
        n_checks++;
        if (so[k] !== 1'b0 || dn[k] !== 1'b0 || sf[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_quiet dut%0d t=%0t: ser_frame/ser_out/done=%b%b%b expected 000",
                   k, $time, sf[k], so[k], dn[k]);
        end
      end
    end
  end

  task automatic test_reset();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({lr[k], bz[k], sf[k], so[k], dn[k]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready/busy/frame/out/done=%b expected 00000",
                 k, {lr[k], bz[k], sf[k], so[k], dn[k]});
      end
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (lr[k] !== 1'b1 || bz[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: ready=%b busy=%b expected 1 0", k, lr[k], bz[k]);
      end
    end
    tick();
  endtask

  task automatic test_msb_first();
    int frame_n = 0, first_c = 0, last_c = 0, done_n = 0, done_c = 0;
    n_checks++;
    if (lr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_idle_ready: got %b expected 1", lr[0]);
    end
    lv[0] = 1'b1;
    ld[0] = 8'hA5;
    push_word(0, 8'hA5);
    tick();
    lv[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (sf[0] === 1'b1) begin
        frame_n++;
        if (first_c == 0) first_c = c;
        last_c = c;
      end
      if (dn[0] === 1'b1) begin
        done_n++;
        done_c = c;
      end
      if (c == 1) begin
        n_checks++;
        if (bz[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL msb_busy: got %b expected 1", bz[0]);
        end
      end
      tick();
    end
    n_checks++;
    if (frame_n != 8 || first_c != 1 || last_c != 8) begin
      n_fail++;
      $display("FAIL msb_frame: %0d cycles from +%0d to +%0d, expected 8 from +1 to +8",
               frame_n, first_c, last_c);
    end
    n_checks++;
    if (done_n != 1 || done_c != 8) begin
      n_fail++;
      $display("FAIL msb_done: %0d pulses last at +%0d, expected 1 at +8", done_n, done_c);
    end
    n_checks++;
    if (bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_busy_end: got %b expected 0", bz[0]);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] words [2];
    int         frame_n;
    words[0] = 8'hA5;
    words[1] = 8'h01;
    for (int w = 0; w < 2; w++) begin
      frame_n = 0;
      lv[1] = 1'b1;
      ld[1] = words[w];
      push_word(1, words[w]);
      tick();
      lv[1] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        if (sf[1] === 1'b1) frame_n++;
        tick();
      end
      n_checks++;
      if (frame_n != 8) begin
        n_fail++;
        $display("FAIL lsb_frame word=%h: %0d frame cycles expected 8", words[w], frame_n);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  frame_n = 0, first_c = 0, last_c = 0, done_n = 0, d1 = 0, d2 = 0, acc = 0;
    bit  pushed = 1'b0, clr = 1'b0;
    lv[0] = 1'b1;
    ld[0] = 8'hFF;
    push_word(0, 8'hFF);
    tick();
    ld[0] = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      if (clr) begin
        lv[0] = 1'b0;
        clr   = 1'b0;
      end
      if (sf[0] === 1'b1) begin
        frame_n++;
        if (first_c == 0) first_c = c;
        last_c = c;
      end
      if (dn[0] === 1'b1) begin
        done_n++;
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
      if (lv[0] && lr[0] === 1'b1 && !pushed) begin
        push_word(0, ld[0]);
        pushed = 1'b1;
        acc    = c;
        clr    = 1'b1;
      end
      tick();
    end
    n_checks++;
    if (acc != 8) begin
      n_fail++;
      $display("FAIL b2b_accept: second word accepted at +%0d expected +8", acc);
    end
    n_checks++;
    if (frame_n != 16 || first_c != 1 || last_c != 16) begin
      n_fail++;
      $display("FAIL b2b_frame: %0d cycles +%0d..+%0d expected 16 contiguous +1..+16",
               frame_n, first_c, last_c);
    end
    n_checks++;
    if (done_n != 2 || d1 != 8 || d2 != 16) begin
      n_fail++;
      $display("FAIL b2b_done: %0d pulses at +%0d,+%0d expected 2 at +8,+16", done_n, d1, d2);
    end
  endtask

  task automatic test_hold_off();
    int acc = 0;
    bit clr = 1'b0;
    lv[0] = 1'b1;
    ld[0] = 8'hA5;
    push_word(0, 8'hA5);
    tick();
    lv[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (clr) begin
        lv[0] = 1'b0;
        clr   = 1'b0;
      end
      if (c == 4) begin
        lv[0] = 1'b1;
        ld[0] = 8'h5A;
      end
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if (lr[0] !== (c == 8)) begin
          n_fail++;
          $display("FAIL hold_ready +%0d: got %b expected %b", c, lr[0], (c == 8));
        end
      end
      if (lv[0] && lr[0] === 1'b1 && acc == 0) begin
        push_word(0, ld[0]);
        acc = c;
        clr = 1'b1;
      end
      tick();
    end
    n_checks++;
    if (acc != 8) begin
      n_fail++;
      $display("FAIL hold_accept: accepted at +%0d expected +8", acc);
    end
  endtask

  task automatic test_gap();
    logic e_sf, e_lr, e_bz;
    lv[2] = 1'b1;
    ld[2] = 8'h3C;
    for (int c = 0; c <= 19; c++) begin
      if (c >= 1) begin
        e_sf = (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
        e_lr = (c == 11);
        e_bz = (c != 11);
        n_checks++;
        if (sf[2] !== e_sf || lr[2] !== e_lr || bz[2] !== e_bz) begin
          n_fail++;
          $display("FAIL gap_timing +%0d: frame/ready/busy=%b%b%b expected %b%b%b",
                   c, sf[2], lr[2], bz[2], e_sf, e_lr, e_bz);
        end
      end
      if (lv[2] && lr[2] === 1'b1) push_word(2, ld[2]);
      if (c == 5) ld[2] = 8'hC3;
      if (c == 19) lv[2] = 1'b0;
      tick();
    end
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (bz[2] !== 1'b0 || lr[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_drain: busy=%b ready=%b expected 0 1", bz[2], lr[2]);
    end
  endtask

  task automatic test_reset_midframe();
    lv[0] = 1'b1;
    ld[0] = 8'hA5;
    push_word(0, 8'hA5);
    tick();
    lv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({so[0], sf[0], bz[0], dn[0], lr[0]} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_now: out/frame/busy/done/ready=%b expected 00000",
               {so[0], sf[0], bz[0], dn[0], lr[0]});
    end
    q0.delete();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (lr[0] !== 1'b1 || bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: ready=%b busy=%b expected 1 0", lr[0], bz[0]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (sf[0] !== 1'b0 || bz[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet +%0d: frame=%b busy=%b expected 0 0", c, sf[0], bz[0]);
      end
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: pending bits %0d/%0d/%0d expected 0/0/0",
               q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    lv  = '0;
    ld  = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_hold_off();
    test_gap();
    test_reset_midframe();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
